// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with valid/ready handshakes on both sides.
// Single-cycle ops (ADD, SUB, AND, OR, XOR, SHL, SHR) produce a result one
// cycle after accept. MUL is an unsigned shift-add multiply that takes WIDTH
// EXEC cycles. The result and the NZCV flags are held until the consumer
// accepts them.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready depends combinationally on out_ready)
//   A, B, opcode        operands and operation (B is also the shift amount)
//   out_valid/out_ready result handshake
//   result              2*WIDTH-bit registered result
//   N, Z, C, V          registered flags
//   busy                multiply in progress
module alu_multicycle #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               N,
  output logic               Z,
  output logic               C,
  output logic               V,
  output logic               busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 accept;
  logic [WIDTH:0]       alu_sum;
  logic [WIDTH-1:0]     alu_dif;
  logic [2*WIDTH-1:0]   a_ext;
  logic [2*WIDTH-1:0]   alu_res;
  logic                 alu_n, alu_z, alu_c, alu_v;
  logic [2*WIDTH-1:0]   mul_acc_next;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_EXEC);
  assign result    = result_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign C         = c_q;
  assign V         = v_q;

  // Single-cycle datapath, evaluated on the live inputs and captured at accept.
  always_comb begin
    alu_sum = {1'b0, A} + {1'b0, B};
    alu_dif = A - B;
    a_ext   = {{WIDTH{1'b0}}, A};
    alu_res = '0;
    alu_n   = 1'b0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_e'(opcode))
      OP_ADD: begin
        alu_res = {{(WIDTH-1){1'b0}}, alu_sum};
        alu_n   = alu_sum[WIDTH-1];
        alu_c   = alu_sum[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (alu_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = {{WIDTH{alu_dif[WIDTH-1]}}, alu_dif};
        alu_n   = alu_dif[WIDTH-1];
        alu_c   = (A >= B);
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (alu_dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND: begin
        alu_res = {{WIDTH{1'b0}}, A & B};
        alu_n   = alu_res[WIDTH-1];
      end
      OP_OR: begin
        alu_res = {{WIDTH{1'b0}}, A | B};
        alu_n   = alu_res[WIDTH-1];
      end
      OP_XOR: begin
        alu_res = {{WIDTH{1'b0}}, A ^ B};
        alu_n   = alu_res[WIDTH-1];
      end
      // Shift amounts at or beyond the vector width naturally yield zero.
      OP_SHL: begin
        alu_res = a_ext << B;
        alu_n   = alu_res[2*WIDTH-1];
      end
      OP_SHR: begin
        alu_res = a_ext >> B;
      end
      default: begin
        alu_res = '0;
      end
    endcase
    alu_z = (alu_res == '0);
  end

  // One shift-add step: add the shifted multiplicand when the current
  // multiplier LSB is set.
  assign mul_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (op_e'(opcode) == OP_MUL) begin
            state_d  = S_EXEC;
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            n_d      = alu_n;
            z_d      = alu_z;
            c_d      = alu_c;
            v_d      = alu_v;
          end
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        acc_d    = mul_acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = mul_acc_next;
          n_d      = 1'b0;
          z_d      = (mul_acc_next == '0);
          c_d      = 1'b0;
          v_d      = (mul_acc_next[2*WIDTH-1:WIDTH] != '0);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      n_q      <= n_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed-vector bench for alu_multicycle (WIDTH=4) with a
// transaction-level reference model and a per-cycle compare process.
module tb_alu_multicycle;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [2:0]     opcode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           N, Z, C, V;
  logic           busy;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .N         (N),
    .Z         (Z),
    .C         (C),
    .V         (V),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the opcode definitions, using signed integer
  // ranges for overflow rather than bit tests.
  typedef struct {
    int r;
    bit n, z, c, v;
  } exp_t;

  function automatic exp_t golden(input int op, input int a, input int b);
    exp_t e;
    int m, h, rm, sa, sb, s, d;
    m  = 1 << W;
    h  = m / 2;
    rm = m * m;
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    e.r = 0; e.n = 0; e.z = 0; e.c = 0; e.v = 0;
    case (op)
      0: begin
        s   = a + b;
        e.r = s;
        e.c = (s >= m);
        e.n = ((s % m) >= h);
        e.v = ((sa + sb) >= h) || ((sa + sb) < -h);
      end
      1: begin
        d   = (a - b + m) % m;
        e.r = (d >= h) ? d + rm - m : d;
        e.n = (d >= h);
        e.c = (a >= b);
        e.v = ((sa - sb) >= h) || ((sa - sb) < -h);
      end
      2: begin e.r = a & b; e.n = (e.r >= h); end
      3: begin e.r = a | b; e.n = (e.r >= h); end
      4: begin e.r = a ^ b; e.n = (e.r >= h); end
      5: begin
        e.r = (b >= 2 * W) ? 0 : ((a << b) % rm);
        e.n = (e.r >= rm / 2);
      end
      6: e.r = (b >= W) ? 0 : (a >> b);
      default: begin
        e.r = a * b;
        e.v = (e.r >= m);
      end
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  // Transaction model: a pending multiply counts down W cycles, a held result
  // stays until taken.
  bit   m_en = 0;
  int   m_busy = 0;
  bit   m_valid = 0;
  exp_t m_out, m_pend;

  always @(posedge clk) begin : model
    exp_t g;
    bit   rdy;
    if (rst) begin
      m_en    <= 1;
      m_busy  <= 0;
      m_valid <= 0;
    end else if (m_en) begin
      rdy = (m_busy == 0 && !m_valid) || (m_valid && out_ready);
      g   = golden(int'(opcode), int'(A), int'(B));
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_valid <= 1;
          m_out   <= m_pend;
        end
      end else if (in_valid && rdy) begin
        if (opcode == 3'b111) begin
          m_busy  <= W;
          m_valid <= 0;
          m_pend  <= g;
        end else begin
          m_valid <= 1;
          m_out   <= g;
        end
      end else if (m_valid && out_ready) begin
        m_valid <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_en && !rst) begin
      chk("in_ready", in_ready, ((m_busy == 0 && !m_valid) || (m_valid && out_ready)) ? 1 : 0);
      chk("out_valid", out_valid, m_valid);
      chk("busy", busy, (m_busy > 0) ? 1 : 0);
      if (m_valid) begin
        chk("result", result, m_out.r);
        chk("N", N, m_out.n);
        chk("Z", Z, m_out.z);
        chk("C", C, m_out.c);
        chk("V", V, m_out.v);
      end
    end
  end

  // Present an operation and hold it until the handshake completes; returns
  // at 1 time unit after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int waited);
    opcode   = op;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    chk("handshake", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [7:0] r,
                            input bit n, input bit z, input bit c, input bit v);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_result"}, result, r);
    chk({name, "_N"}, N, n);
    chk({name, "_Z"}, Z, z);
    chk({name, "_C"}, C, c);
    chk({name, "_V"}, V, v);
  endtask

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  vec_t vecs[14] = '{
    '{3'd0, 4'd7,  4'd1},  '{3'd1, 4'd8,  4'd1},  '{3'd2, 4'hC, 4'hA},
    '{3'd3, 4'h8, 4'h1},   '{3'd7, 4'd13, 4'd11}, '{3'd5, 4'd15, 4'd7},
    '{3'd5, 4'd1,  4'd15}, '{3'd6, 4'd15, 4'd4},  '{3'd6, 4'd15, 4'd3},
    '{3'd1, 4'd0,  4'd0},  '{3'd7, 4'd0,  4'd9},  '{3'd0, 4'd15, 4'd15},
    '{3'd4, 4'hF, 4'hF},   '{3'd7, 4'd3,  4'd5}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    opcode    = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {N, Z, C, V}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD 9+9: carry and signed overflow, latency 1
    send(3'b000, 4'd9, 4'd9, w);
    @(negedge clk);
    expect_out("add99", 8'h12, 0, 0, 1, 1);
    @(posedge clk); #1;

    send(3'b001, 4'd3, 4'd5, w);
    @(negedge clk);
    expect_out("sub35", 8'hFE, 1, 0, 0, 0);
    @(posedge clk); #1;

    send(3'b001, 4'd5, 4'd5, w);
    @(negedge clk);
    expect_out("sub55", 8'h00, 0, 1, 1, 0);
    @(posedge clk); #1;

    // MUL 15*15: four busy cycles, result on the fifth
    send(3'b111, 4'd15, 4'd15, w);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mul_busy", busy, 1);
      chk("mul_in_ready", in_ready, 0);
      chk("mul_out_valid", out_valid, 0);
    end
    @(negedge clk);
    expect_out("mul1515", 8'hE1, 0, 0, 0, 1);
    @(posedge clk); #1;

    send(3'b101, 4'b1011, 4'd2, w);
    @(negedge clk);
    expect_out("shl2", 8'h2C, 0, 0, 0, 0);
    @(posedge clk); #1;

    send(3'b101, 4'b1011, 4'd9, w);
    @(negedge clk);
    expect_out("shl9", 8'h00, 0, 1, 0, 0);
    @(posedge clk); #1;

    send(3'b110, 4'b1011, 4'd1, w);
    @(negedge clk);
    expect_out("shr1", 8'h05, 0, 0, 0, 0);
    @(posedge clk); #1;

    // Backpressure: result held, then released with a same-cycle accept
    out_ready = 1'b0;
    send(3'b100, 4'hA, 4'h5, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 8'h0F);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'b000, 4'd1, 4'd1, w);
    chk("b2b_wait", w, 0);
    @(negedge clk);
    expect_out("b2b_add", 8'h02, 0, 0, 0, 0);
    @(posedge clk); #1;

    // Reset during the second EXEC cycle of a multiply
    send(3'b111, 4'd7, 4'd3, w);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_result", result, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    @(posedge clk); #1;
    send(3'b000, 4'd2, 4'd3, w);
    @(negedge clk);
    expect_out("add23", 8'h05, 0, 0, 0, 0);
    @(posedge clk); #1;

    // Streaming pass with in_valid held high; the compare process checks it
    in_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      opcode = vecs[i].op;
      A      = vecs[i].a;
      B      = vecs[i].b;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Same vectors with out_ready toggling every cycle
    in_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      opcode    = vecs[i].op;
      A         = vecs[i].a;
      B         = vecs[i].b;
      out_ready = i[0];
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
